uart_frame_ctrl: RTL
====================

Name: uart_frame_ctrl

Overview:
Read-side controller for the UART receive FIFO. It pops bytes from the FIFO whenever data is present and parses them into framed packets: SOF, LEN, payload, XOR checksum. Payload bytes stream to downstream logic with start/last markers, followed by a one-cycle OK or error verdict. It sits between the RX FIFO read port and the command/register logic.

Parameters:
SOF, 8'hA5, start-of-frame byte.
MAX_LEN, 16, largest legal payload length in bytes (1..255).
TIMEOUT_CYC, 1000, consecutive idle cycles mid-frame before the frame is aborted.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
fifo_empty  in  1  RX FIFO empty flag
fifo_dout  in  8  RX FIFO read data, valid the cycle after fifo_rd_en
fifo_rd_en  out  1  FIFO pop request
pkt_data  out  8  payload byte
pkt_valid  out  1  pkt_data valid strobe
pkt_start  out  1  first payload byte of the frame, qualified by pkt_valid
pkt_last  out  1  last payload byte of the frame, qualified by pkt_valid
pkt_ok  out  1  one-cycle pulse: frame checksum good
pkt_err  out  1  one-cycle pulse: frame aborted
err_code  out  2  valid with pkt_err: 01 checksum, 10 bad length, 11 timeout
busy  out  1  state is not HUNT
frame_cnt  out  16  count of good frames, wraps 16'hFFFF->0

Behaviour:
- Reset: synchronous, active-high, on rising clk. All outputs 0, state HUNT, timeout counter 0, frame_cnt 0. A read in flight at reset is discarded.
- Fetch logic:
  - fifo_rd_en = !fifo_empty && !rst. Back-to-back pops are allowed.
  - byte_vld is fifo_rd_en registered; fifo_dout is sampled when byte_vld=1.
  - Each sampled byte is processed by the FSM in that same cycle.
- FSM, advancing only on byte_vld:
  - HUNT: byte==SOF -> LEN. Any other byte is dropped silently, with no error.
  - LEN: if byte==0 or byte>MAX_LEN -> pkt_err, err_code=10, go to HUNT. Otherwise store len, chk=byte, cnt=0, go to PAY.
  - PAY: emit the byte, chk^=byte, cnt++. When cnt reaches len -> CHK.
  - CHK: if byte==chk -> pkt_ok and frame_cnt+1; else pkt_err with err_code=01. Go to HUNT either way.
  - A SOF value inside LEN, PAY or CHK is treated as data; there is no resync mid-frame.
- Output timing:
  - pkt_* and verdict outputs are registered. They appear the cycle after byte_vld, i.e. 2 cycles after the corresponding fifo_rd_en.
  - pkt_start is asserted with cnt==0 and pkt_last with cnt==len-1. Both are set together when len==1.
  - pkt_ok/pkt_err pulse for exactly 1 cycle and are never asserted together.
- Error semantics: payload is streamed before verification. Downstream discards the frame on pkt_err.
- Timeout:
  - In LEN, PAY or CHK, the counter increments on each cycle with fifo_empty=1 and byte_vld=0, and clears on byte_vld.
  - Reaching TIMEOUT_CYC-1 -> pkt_err with err_code=11, go to HUNT, counter cleared.
  - No read is outstanding at that point, so no byte is lost.
  - The counter is held at 0 in HUNT.
- busy = (state != HUNT), registered with state.
- Simultaneous events: reset wins over everything. A byte_vld in the same cycle as a timeout cannot occur, because timeout requires byte_vld=0.

Test Plan:
- Good frame: FIFO holds A5 03 11 22 33 03 -> pkt_valid on 3 cycles with data 11,22,33; pkt_start on 11 and pkt_last on 33; pkt_ok 1 cycle after the checksum byte; frame_cnt=1; busy falls afterwards.
- Bad checksum: A5 02 AA 55 00 (expected FD) -> payload AA,55 emitted, then pkt_err with err_code=01; frame_cnt unchanged.
- Bad length: A5 00, then A5 11 (17>MAX_LEN) -> two pkt_err pulses with err_code=10; no pkt_valid; FSM back in HUNT.
- Garbage plus resync: 00 FF 13 A5 01 7E 7F -> leading garbage dropped without error; single pkt_valid on 7E with start and last both high; pkt_ok.
- Timeout: A5 04 01, then FIFO empty for TIMEOUT_CYC cycles -> pkt_err with err_code=11 exactly TIMEOUT_CYC cycles after the last byte_vld; then a following good frame passes.
- Reset mid-frame: assert rst during PAY of a 4-byte frame -> next cycle all outputs 0, busy=0, frame_cnt=0; remaining bytes are hunted as garbage until the next A5.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// Purpose : pops the UART RX FIFO and parses SOF/LEN/payload/XOR-checksum frames into a payload stream plus an OK/error verdict.
// Latency : fifo_rd_en -> byte_vld 1 cycle; byte_vld -> pkt_*/verdict outputs 1 cycle (2 cycles after the pop).
// Backpr. : none downstream; pops whenever the FIFO is non-empty, so consumers must accept one byte per cycle.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   fifo_empty        RX FIFO empty flag
//   fifo_dout[7:0]    RX FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en        FIFO pop request
//   pkt_data[7:0]     payload byte, qualified by pkt_valid
//   pkt_valid         payload strobe
//   pkt_start/last    first/last payload byte of the frame (qualified by pkt_valid)
//   pkt_ok / pkt_err  one-cycle verdict pulses
//   err_code[1:0]     with pkt_err: 01 checksum, 10 bad length, 11 timeout
//   busy              parser is inside a frame
//   frame_cnt[15:0]   count of good frames, wrapping
module uart_frame_ctrl #(
    parameter logic [7:0] SOF         = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic [7:0]  pkt_data,
    output logic        pkt_valid,
    output logic        pkt_start,
    output logic        pkt_last,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int              TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHK = 2'b01;
    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TO  = 2'b11;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_byte_vld;
    logic [7:0]      r_len, w_len_nxt;
    logic [7:0]      r_chk, w_chk_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [TO_W-1:0] r_to_cnt, w_to_nxt;
    logic [7:0]      w_cnt_inc;
    logic [TO_W-1:0] w_to_inc;

    logic [7:0]  r_pkt_data, w_data_nxt;
    logic        r_pkt_valid, w_vld_nxt;
    logic        r_pkt_start, w_start_nxt;
    logic        r_pkt_last, w_last_nxt;
    logic        r_pkt_ok, w_ok_nxt;
    logic        r_pkt_err, w_err_nxt;
    logic [1:0]  r_err_code, w_code_nxt;
    logic [15:0] r_frame_cnt;

    // Pop whenever data is present; reset blocks the pop so nothing is lost.
    assign fifo_rd_en = !fifo_empty && !rst;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_to_inc  = r_to_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_chk_nxt   = r_chk;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to_cnt;
        w_data_nxt  = r_pkt_data;
        w_vld_nxt   = 1'b0;
        w_start_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_ok_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = 2'b00;

        // Idle timer: only runs mid-frame while starved; any byte restarts it.
        // Timeout and byte_vld are mutually exclusive, so the byte case below
        // never overrides a timeout verdict.
        if (r_state == ST_HUNT || r_byte_vld) begin
            w_to_nxt = '0;
        end else if (fifo_empty) begin
            if (w_to_inc == TO_LIMIT) begin
                w_err_nxt   = 1'b1;
                w_code_nxt  = ERR_TO;
                w_state_nxt = ST_HUNT;
                w_to_nxt    = '0;
            end else begin
                w_to_nxt = w_to_inc;
            end
        end

        if (r_byte_vld) begin
            case (r_state)
                ST_HUNT: begin
                    if (fifo_dout == SOF) begin
                        w_state_nxt = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (fifo_dout == 8'd0 || fifo_dout > MAX_LEN_B) begin
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = ERR_LEN;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_len_nxt   = fifo_dout;
                        w_chk_nxt   = fifo_dout;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = ST_PAY;
                    end
                end
                ST_PAY: begin
                    // Payload is forwarded before the checksum is known.
                    w_vld_nxt   = 1'b1;
                    w_data_nxt  = fifo_dout;
                    w_start_nxt = (r_cnt == 8'd0);
                    w_last_nxt  = (w_cnt_inc == r_len);
                    w_chk_nxt   = r_chk ^ fifo_dout;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (fifo_dout == r_chk) begin
                        w_ok_nxt = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_CHK;
                    end
                    w_state_nxt = ST_HUNT;
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_byte_vld  <= 1'b0;
            r_len       <= 8'd0;
            r_chk       <= 8'd0;
            r_cnt       <= 8'd0;
            r_to_cnt    <= '0;
            r_pkt_data  <= 8'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_start <= 1'b0;
            r_pkt_last  <= 1'b0;
            r_pkt_ok    <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= 2'b00;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_vld  <= fifo_rd_en;
            r_len       <= w_len_nxt;
            r_chk       <= w_chk_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to_cnt    <= w_to_nxt;
            r_pkt_data  <= w_data_nxt;
            r_pkt_valid <= w_vld_nxt;
            r_pkt_start <= w_start_nxt;
            r_pkt_last  <= w_last_nxt;
            r_pkt_ok    <= w_ok_nxt;
            r_pkt_err   <= w_err_nxt;
            r_err_code  <= w_code_nxt;
            if (w_ok_nxt) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign pkt_data  = r_pkt_data;
    assign pkt_valid = r_pkt_valid;
    assign pkt_start = r_pkt_start;
    assign pkt_last  = r_pkt_last;
    assign pkt_ok    = r_pkt_ok;
    assign pkt_err   = r_pkt_err;
    assign err_code  = r_err_code;
    assign busy      = (r_state != ST_HUNT);
    assign frame_cnt = r_frame_cnt;

endmodule
